imm_ext_stage: RTL
==================

# imm_ext_stage

Pipelined, parametrised immediate-extension stage for the decode path. Takes a full instruction word and an immediate-format select, and produces a sign- or zero-extended immediate of `DATA_WIDTH` bits. Covers I, S, B, U, J and CSR-zimm formats. Sits between fetch/decode and the execute register. Uses a valid/ready handshake with a 2-entry skid buffer, giving full throughput with registered `in_ready`, plus flush support for branch redirects.

## Interface
- `DATA_WIDTH`, 32, output immediate width; legal values ≥ 32 (32 = RV32, 64 = RV64).
- `INSTR_WIDTH`, 32, instruction word width; fixed at 32, parameterised for lint only.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset. **Synchronous, active-low; one clock.**
- `flush` input 1: discard all buffered entries and any same-cycle input.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: registered; stage can accept a beat.
- `instr` input `INSTR_WIDTH`: instruction word.
- `imm_src` input 3: format select (`imm_src_t`).
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: downstream accepts.
- `imm_op` output `DATA_WIDTH`: extended immediate.
- `imm_illegal` output 1: the beat's `imm_src` was an undefined code.

## Operation
- Field extraction, with `s` = `instr[31]` replicated to fill `DATA_WIDTH`:
  - I: `{s, instr[31:20]}`
  - S: `{s, instr[31:25], instr[11:7]}`
  - B: `{s, instr[7], instr[30:25], instr[11:8], 0}`
  - U: `{s, instr[31:12], 12'b0}`
  - J: `{s, instr[19:12], instr[20], instr[30:21], 0}`
  - Z: `{0, instr[19:15]}`, zero-extended.
- Codes 6 and 7 are illegal: `imm_op` = 0 and `imm_illegal` = 1. The beat still flows, with no error stall.
- Extension is computed combinationally at the input and stored. The output is driven from the head buffer entry, never from the input.
- Buffer is 2 entries, FIFO order, and holds `{imm_op, imm_illegal}`.
- Occupancy states:
  - EMPTY: `in_ready` = 1, `out_valid` = 0.
  - ONE: `in_ready` = 1, `out_valid` = 1.
  - FULL: `in_ready` = 0, `out_valid` = 1.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Occupancy transitions:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together in ONE: stays ONE, head is replaced by the new beat.
  - Push is impossible in FULL.
- `in_ready` next = (next occupancy < 2).
- `flush`: next state EMPTY, and any same-cycle push is dropped. `flush` has priority over push and pop. A same-cycle pop still counts as transferred downstream, and downstream is responsible for ignoring it.
- Reset: same effect as flush. Reset values: `out_valid` = 0, `imm_op` = 0, `imm_illegal` = 0, `in_ready` = 1.

## Timing
- Latency: an input accepted at edge N appears on `imm_op` after edge N, i.e. in cycle N+1, if the buffer was empty.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- `in_ready` and `out_valid` depend only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- `imm_op` and `imm_illegal` hold stable while `out_valid & !out_ready`.
- Reset asserted mid-stream: on the next edge all state is cleared. Beats in flight are lost by design.
- Flush and reset asserted together behave as reset.

## Structure
- Shared package `imm_pkg` contains:
  - `imm_src_t`, a 3-bit enum: `IMM_I`=0, `IMM_S`=1, `IMM_B`=2, `IMM_U`=3, `IMM_J`=4, `IMM_Z`=5.
  - Constant `IMM_SRC_W` = 3.
  - Function `is_legal_imm_src`.
- Sub-module `imm_ext_comb` holds pure combinational extraction and extension, parameterised on `DATA_WIDTH`, and is reusable by the decoder.
- Top level holds only the skid buffer and control logic.

## Test plan
- Formats, `DATA_WIDTH`=32, `out_ready`=1:
  - I `0xFFF00093` → `0xFFFFFFFF`
  - S `0xFE112E23` → `0xFFFFFFFC`
  - B `0xFE000CE3` → `0xFFFFFFF8`
  - U `0x123452B7` → `0x12345000`
  - J `0x001000EF` → `0x00000800`
  - Each appears one cycle after acceptance.
- `DATA_WIDTH`=64:
  - I `0xFFF00093` → `0xFFFFFFFFFFFFFFFF`.
  - Z with `instr[19:15]`=`0x1F` → `0x1F`, with the upper bits 0.
- Backpressure: stream 5 beats with `out_ready` = 0 for 3 cycles.
  - `in_ready` falls after 2 accepts.
  - All 5 outputs emerge in order with no duplicates.
  - `imm_op` is stable while stalled.
- Illegal: `imm_src`=7 → `imm_op`=0, `imm_illegal`=1. The following legal beat has `imm_illegal`=0.
- Flush with FULL buffer and `in_valid`=1:
  - Next cycle: `out_valid`=0, `in_ready`=1.
  - The dropped beat never appears.
- Reset mid-stream: drive `rst_n`=0 for one edge with 2 entries buffered.
  - Outputs return to the reset values: `out_valid` 0, `imm_op` 0, `imm_illegal` 0, `in_ready` 1.
  - The first post-reset beat has 1-cycle latency.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the decode path.
// Holds the format-select encoding and the occupancy states of the extension stage buffer.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_src_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic logic is_legal_imm_src(input logic [IMM_SRC_W-1:0] src);
        return src <= IMM_Z;
    endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Pure combinational immediate extraction and extension; zero latency, no handshake.
// Undefined format codes yield a zero immediate with illegal_o raised.
module imm_ext_comb
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [IMM_SRC_W-1:0]   imm_src_i,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic                   illegal_o
);

    logic [31:0]           raw;
    logic [DATA_WIDTH-1:0] ext;
    logic                  unused_opcode;

    assign unused_opcode = ^instr_i[6:0];

    // raw[31] already carries the correct fill bit for every format (0 for Z and illegal)
    always_comb begin
        raw = '0;
        case (imm_src_i)
            IMM_I:   raw = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U:   raw = {instr_i[31:12], 12'b0};
            IMM_J:   raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            IMM_Z:   raw = {27'b0, instr_i[19:15]};
            default: raw = '0;
        endcase
        ext = {DATA_WIDTH{raw[31]}};
        ext[31:0] = raw;
    end

    assign imm_o     = ext;
    assign illegal_o = !is_legal_imm_src(imm_src_i);

endmodule

// File: rtl/imm_ext_stage.sv
// Immediate-extension stage with a 2-entry skid buffer; 1-cycle latency when empty.
// in_ready is registered and deasserts only when both entries are held; flush/reset empty the buffer.
module imm_ext_stage
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [IMM_SRC_W-1:0]   imm_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  imm_op,
    output logic                   imm_illegal
);

    logic [DATA_WIDTH-1:0] new_imm;
    logic                  new_ill;

    imm_ext_comb #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ext (
        .instr_i   (instr),
        .imm_src_i (imm_src),
        .imm_o     (new_imm),
        .illegal_o (new_ill)
    );

    occ_t                  state_q;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] head_imm_q;
    logic                  head_ill_q;
    logic [DATA_WIDTH-1:0] tail_imm_q;
    logic                  tail_ill_q;
    logic                  push;
    logic                  pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            head_imm_q <= '0;
            head_ill_q <= 1'b0;
            tail_imm_q <= '0;
            tail_ill_q <= 1'b0;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_imm_q <= new_imm;
                        head_ill_q <= new_ill;
                        state_q    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_imm_q <= new_imm;
                        head_ill_q <= new_ill;
                    end else if (push) begin
                        tail_imm_q <= new_imm;
                        tail_ill_q <= new_ill;
                        state_q    <= OCC_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_imm_q <= tail_imm_q;
                        head_ill_q <= tail_ill_q;
                        state_q    <= OCC_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= OCC_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != OCC_EMPTY);
    assign imm_op      = head_imm_q;
    assign imm_illegal = head_ill_q;

endmodule
